// File: rtl/edulent_mem_pkg.sv
// rtl/edulent_mem_pkg.sv - shared types and constants for the program/data RAM arbiter
package edulent_mem_pkg;

  // Default RAM geometry, shared with the RAM wrapper.
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Port identifiers, also the encoding of last_grant.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way winner select for the RAM arbiter
//
// Ports:
//   req0_i       CPU request
//   req1_i       loader request
//   last_grant_i port that won the previous access
//   valid_o      at least one request present
//   port_o       winning port id (PORT_CPU / PORT_LDR)
module mem_arb_pick
  import edulent_mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic port_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    port_o  = PORT_CPU;
    if (req0_i && req1_i) begin
      // Contention: CPU always wins in fixed mode, otherwise the port
      // that did not win last time.
      port_o = FIXED_PRIO ? PORT_CPU : ~last_grant_i;
    end else if (req1_i) begin
      port_o = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sharing one synchronous-read RAM
//
// Ports:
//   i_clk, i_rst               clock, async active-high reset
//   i_reqN/i_weN/i_addrN/i_wdataN  port N command (0 = CPU, 1 = loader)
//   o_gntN                     pulse: port N command issued to the RAM
//   o_rvalidN/o_rdataN         pulse + held read result for port N
//   o_mem_en/we/addr/wdata     registered RAM command
//   i_mem_rdata                RAM read data, valid the cycle after a read
module mem_arbiter
  import edulent_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  arb_state_t        state_q;
  logic              last_grant_q;
  logic              gnt0_q, gnt1_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              win_valid_d;
  logic              win_port_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  mem_arb_pick #(
    .FIXED_PRIO(FIXED_PRIO != 0)
  ) u_pick (
    .req0_i      (i_req0),
    .req1_i      (i_req1),
    .last_grant_i(last_grant_q),
    .valid_o     (win_valid_d),
    .port_o      (win_port_d)
  );

  assign sel_we_d    = (win_port_d == PORT_LDR) ? i_we1    : i_we0;
  assign sel_addr_d  = (win_port_d == PORT_LDR) ? i_addr1  : i_addr0;
  assign sel_wdata_d = (win_port_d == PORT_LDR) ? i_wdata1 : i_wdata0;

  // The RAM command registers double as the request latch, and last_grant_q
  // doubles as the latched port id since it is updated on every issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_LDR;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid_d) begin
            state_q      <= ISSUE;
            last_grant_q <= win_port_d;
            gnt0_q       <= (win_port_d == PORT_CPU);
            gnt1_q       <= (win_port_d == PORT_LDR);
            mem_en_q     <= 1'b1;
            mem_we_q     <= sel_we_d;
            mem_addr_q   <= sel_addr_d;
            mem_wdata_q  <= sel_wdata_d;
          end
        end
        ISSUE: begin
          // mem_we_q still holds the issued command's direction here.
          state_q <= mem_we_q ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          state_q <= IDLE;
          if (last_grant_q == PORT_CPU) begin
            rdata0_q  <= i_mem_rdata;
            rvalid0_q <= 1'b1;
          end else begin
            rdata1_q  <= i_mem_rdata;
            rvalid1_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gnt0      = gnt0_q;
  assign o_gnt1      = gnt1_q;
  assign o_rvalid0   = rvalid0_q;
  assign o_rvalid1   = rvalid1_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (round-robin and fixed-priority instances)
module tb_mem_arbiter;

  localparam int NC = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  always #5 clk = ~clk;

  // Inputs indexed [instance][port]; instance 0 = round-robin, 1 = fixed.
  logic       req_r   [2][2];
  logic       we_r    [2][2];
  logic [7:0] addr_r  [2][2];
  logic [7:0] wdata_r [2][2];

  wire       gnt0_w [2];
  wire       gnt1_w [2];
  wire       rv0_w  [2];
  wire       rv1_w  [2];
  wire [7:0] rd0_w  [2];
  wire [7:0] rd1_w  [2];
  wire       en_w   [2];
  wire       mwe_w  [2];
  wire [7:0] maddr_w[2];
  wire [7:0] mwd_w  [2];

  function automatic logic [7:0] ram_init(input logic [7:0] a);
    logic [7:0] v;
    v = a * 8'd7 + 8'd3;
    return (a == 8'h10) ? 8'hA5 : v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] ram [256];
    logic       wr  [256];
    logic [7:0] rd_q;

    always @(posedge clk) begin
      if (ram_clr) begin
        for (int i = 0; i < 256; i++) wr[i] <= 1'b0;
        rd_q <= 8'h00;
      end else if (en_w[g]) begin
        if (mwe_w[g]) begin
          ram[maddr_w[g]] <= mwd_w[g];
          wr[maddr_w[g]]  <= 1'b1;
        end
        rd_q <= wr[maddr_w[g]] ? ram[maddr_w[g]] : ram_init(maddr_w[g]);
      end
    end

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(g)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req_r[g][0]), .i_req1(req_r[g][1]),
      .i_we0(we_r[g][0]), .i_we1(we_r[g][1]),
      .i_addr0(addr_r[g][0]), .i_addr1(addr_r[g][1]),
      .i_wdata0(wdata_r[g][0]), .i_wdata1(wdata_r[g][1]),
      .o_gnt0(gnt0_w[g]), .o_gnt1(gnt1_w[g]),
      .o_rvalid0(rv0_w[g]), .o_rvalid1(rv1_w[g]),
      .o_rdata0(rd0_w[g]), .o_rdata1(rd1_w[g]),
      .o_mem_en(en_w[g]), .o_mem_we(mwe_w[g]),
      .o_mem_addr(maddr_w[g]), .o_mem_wdata(mwd_w[g]),
      .i_mem_rdata(rd_q)
    );
  end

  // Reference model: transaction events scheduled by cycle number.
  bit         iss_v    [2][NC];
  bit         iss_port [2][NC];
  bit         iss_we   [2][NC];
  logic [7:0] iss_addr [2][NC];
  logic [7:0] iss_wdata[2][NC];
  bit         rv_v     [2][2][NC];
  logic [7:0] rv_d     [2][2][NC];
  int         idle_at  [2];
  bit         last     [2];
  logic [7:0] ref_mem  [2][256];
  logic [7:0] h_addr   [2];
  logic [7:0] h_wdata  [2];
  logic [7:0] h_rd     [2][2];

  // Requester state.
  bit         pend [2][2];
  bit         q_we [2][2];
  logic [7:0] q_addr[2][2];
  logic [7:0] q_wd [2][2];

  int k;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s inst%0d cycle%0d: got %0h want %0h", tag, d, k, obs, exp_v);
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      if (iss_v[d][k]) begin
        h_addr[d]  = iss_addr[d][k];
        h_wdata[d] = iss_wdata[d][k];
      end
      for (int p = 0; p < 2; p++)
        if (rv_v[d][p][k]) h_rd[d][p] = rv_d[d][p][k];
      chk("gnt0", d, {7'd0, gnt0_w[d]}, {7'd0, iss_v[d][k] && iss_port[d][k] == 1'b0});
      chk("gnt1", d, {7'd0, gnt1_w[d]}, {7'd0, iss_v[d][k] && iss_port[d][k] == 1'b1});
      chk("rvalid0", d, {7'd0, rv0_w[d]}, {7'd0, rv_v[d][0][k]});
      chk("rvalid1", d, {7'd0, rv1_w[d]}, {7'd0, rv_v[d][1][k]});
      chk("rdata0", d, rd0_w[d], h_rd[d][0]);
      chk("rdata1", d, rd1_w[d], h_rd[d][1]);
      chk("mem_en", d, {7'd0, en_w[d]}, {7'd0, iss_v[d][k]});
      chk("mem_we", d, {7'd0, mwe_w[d]}, {7'd0, iss_v[d][k] && iss_we[d][k]});
      chk("mem_addr", d, maddr_w[d], h_addr[d]);
      chk("mem_wdata", d, mwd_w[d], h_wdata[d]);
    end
  endtask

  // Arbiter rules at transaction level: when free, pick a winner; a grant
  // shows next cycle, a read returns three cycles later, a write frees the
  // arbiter two cycles later.
  task automatic model_update();
    bit w;
    for (int d = 0; d < 2; d++) begin
      if (k >= idle_at[d] && (req_r[d][0] || req_r[d][1])) begin
        if (req_r[d][0] && req_r[d][1]) w = (d == 1) ? 1'b0 : ~last[d];
        else w = req_r[d][1];
        last[d] = w;
        iss_v[d][k+1]     = 1'b1;
        iss_port[d][k+1]  = w;
        iss_we[d][k+1]    = we_r[d][w];
        iss_addr[d][k+1]  = addr_r[d][w];
        iss_wdata[d][k+1] = wdata_r[d][w];
        if (we_r[d][w]) begin
          ref_mem[d][addr_r[d][w]] = wdata_r[d][w];
          idle_at[d] = k + 2;
        end else begin
          rv_v[d][w][k+3] = 1'b1;
          rv_d[d][w][k+3] = ref_mem[d][addr_r[d][w]];
          idle_at[d] = k + 3;
        end
      end
    end
  endtask

  task automatic post(input int d, input int p, input bit w, input logic [7:0] a, input logic [7:0] wd);
    pend[d][p] = 1'b1;
    q_we[d][p] = w;
    q_addr[d][p] = a;
    q_wd[d][p] = wd;
  endtask

  // mode 0: hold only; 1: continuous reads both ports; 2: continuous reads port 1; 3: random
  task automatic cyc(input int mode);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        if (mode == 3) begin
          if (pend[d][p] && $urandom_range(15) == 0) pend[d][p] = 1'b0;
          else if (!pend[d][p] && $urandom_range(1) == 1)
            post(d, p, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
        end else if ((mode == 1 || (mode == 2 && p == 1)) && !pend[d][p]) begin
          post(d, p, 1'b0, 8'($urandom_range(15)), 8'($urandom));
        end
        req_r[d][p]   = pend[d][p];
        we_r[d][p]    = q_we[d][p];
        addr_r[d][p]  = q_addr[d][p];
        wdata_r[d][p] = q_wd[d][p];
      end
    model_update();
    @(negedge clk);
    k++;
    check_cycle();
    for (int d = 0; d < 2; d++)
      if (iss_v[d][k]) pend[d][iss_port[d][k]] = 1'b0;
  endtask

  task automatic chk_all_zero();
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt0", d, {7'd0, gnt0_w[d]}, 8'h00);
      chk("rst_gnt1", d, {7'd0, gnt1_w[d]}, 8'h00);
      chk("rst_rvalid0", d, {7'd0, rv0_w[d]}, 8'h00);
      chk("rst_rvalid1", d, {7'd0, rv1_w[d]}, 8'h00);
      chk("rst_rdata0", d, rd0_w[d], 8'h00);
      chk("rst_rdata1", d, rd1_w[d], 8'h00);
      chk("rst_mem_en", d, {7'd0, en_w[d]}, 8'h00);
      chk("rst_mem_we", d, {7'd0, mwe_w[d]}, 8'h00);
      chk("rst_mem_addr", d, maddr_w[d], 8'h00);
      chk("rst_mem_wdata", d, mwd_w[d], 8'h00);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_all_zero();
    for (int d = 0; d < 2; d++) begin
      for (int i = k + 1; i < NC; i++) begin
        iss_v[d][i] = 1'b0;
        rv_v[d][0][i] = 1'b0;
        rv_v[d][1][i] = 1'b0;
      end
      last[d] = 1'b1;
      h_addr[d] = 8'h00;
      h_wdata[d] = 8'h00;
      for (int p = 0; p < 2; p++) begin
        h_rd[d][p] = 8'h00;
        pend[d][p] = 1'b0;
        req_r[d][p] = 1'b0;
      end
    end
    @(negedge clk);
    k++;
    rst = 1'b0;
    idle_at[0] = k;
    idle_at[1] = k;
    check_cycle();
  endtask

  initial begin
    k = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) ref_mem[d][i] = ram_init(8'(i));
      for (int p = 0; p < 2; p++) begin
        req_r[d][p] = 1'b0; we_r[d][p] = 1'b0; addr_r[d][p] = 8'h00; wdata_r[d][p] = 8'h00;
        pend[d][p] = 1'b0; q_we[d][p] = 1'b0; q_addr[d][p] = 8'h00; q_wd[d][p] = 8'h00;
        h_rd[d][p] = 8'h00;
      end
      h_addr[d] = 8'h00; h_wdata[d] = 8'h00;
      last[d] = 1'b1; idle_at[d] = 0;
    end

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    ram_clr = 1'b0;
    chk_all_zero();
    rst = 1'b0;
    check_cycle();

    // Port 0 read of 0x10 (preloaded 0xA5).
    post(0, 0, 1'b0, 8'h10, 8'h00);
    post(1, 0, 1'b0, 8'h10, 8'h00);
    cyc(0);
    chk("t1_gnt0", 0, {7'd0, gnt0_w[0]}, 8'h01);
    chk("t1_gnt1", 0, {7'd0, gnt1_w[0]}, 8'h00);
    chk("t1_addr", 0, maddr_w[0], 8'h10);
    cyc(0);
    cyc(0);
    chk("t1_rvalid0", 0, {7'd0, rv0_w[0]}, 8'h01);
    chk("t1_rdata0", 0, rd0_w[0], 8'hA5);

    // Port 1 writes 0x3C to 0x20 while port 0 waits to read 0x20.
    for (int d = 0; d < 2; d++) begin
      post(d, 1, 1'b1, 8'h20, 8'h3C);
      post(d, 0, 1'b0, 8'h20, 8'h00);
    end
    cyc(0);
    chk("t2_gnt1", 0, {7'd0, gnt1_w[0]}, 8'h01);
    chk("t2_we", 0, {7'd0, mwe_w[0]}, 8'h01);
    cyc(0);
    cyc(0);
    chk("t2_gnt0", 0, {7'd0, gnt0_w[0]}, 8'h01);
    cyc(0);
    cyc(0);
    chk("t2_rvalid0", 0, {7'd0, rv0_w[0]}, 8'h01);
    chk("t2_rdata0", 0, rd0_w[0], 8'h3C);
    repeat (4) cyc(0);

    // Reset during CAPTURE of a port 1 read; then contention after reset.
    post(0, 1, 1'b0, 8'h05, 8'h00);
    post(1, 1, 1'b0, 8'h05, 8'h00);
    cyc(0);
    cyc(0);
    do_reset();
    for (int d = 0; d < 2; d++) begin
      post(d, 0, 1'b0, 8'h01, 8'h00);
      post(d, 1, 1'b0, 8'h02, 8'h00);
    end
    cyc(0);
    chk("rst_first_gnt0_rr", 0, {7'd0, gnt0_w[0]}, 8'h01);
    chk("rst_first_gnt0_fp", 1, {7'd0, gnt0_w[1]}, 8'h01);
    repeat (8) cyc(0);

    // Continuous reads from both ports, then port 0 stops.
    repeat (24) cyc(1);
    pend[0][0] = 1'b0;
    pend[1][0] = 1'b0;
    repeat (12) cyc(2);
    for (int d = 0; d < 2; d++) pend[d][1] = 1'b0;
    repeat (6) cyc(0);

    // req0 raised only while busy and dropped before IDLE: no access.
    post(0, 1, 1'b0, 8'h07, 8'h00);
    post(1, 1, 1'b0, 8'h07, 8'h00);
    cyc(0);
    post(0, 0, 1'b0, 8'h09, 8'h00);
    post(1, 0, 1'b0, 8'h09, 8'h00);
    cyc(0);
    pend[0][0] = 1'b0;
    pend[1][0] = 1'b0;
    repeat (4) cyc(0);

    // Randomized traffic with a reset in the middle.
    repeat (300) cyc(3);
    do_reset();
    repeat (300) cyc(3);
    repeat (6) cyc(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single synchronous-read program/data RAM between the CPU memory path and the program loader/debug port. The CPU memory path covers the MA/MD transfers issued by the control sequencer. The arbiter latches one request at a time, drives the RAM, and returns read data to the winning port with a valid pulse. It sits between the datapath's memory interface, the loader, and the RAM macro.

## Interface
- ADDR_W, 8, address width of RAM and both ports
- DATA_W, 8, data width
- FIXED_PRIO, 0, 0 selects round-robin arbitration; 1 gives port 0 (CPU) absolute priority

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req0 / i_req1  in  1  access request, port 0 = CPU, port 1 = loader
- i_we0 / i_we1  in  1  1 = write, 0 = read; qualified by req
- i_addr0 / i_addr1  in  ADDR_W  access address
- i_wdata0 / i_wdata1  in  DATA_W  write data
- o_gnt0 / o_gnt1  out  1  one-cycle pulse: command accepted and issued to RAM
- o_rvalid0 / o_rvalid1  out  1  one-cycle pulse: o_rdataN updated with read result
- o_rdata0 / o_rdata1  out  DATA_W  last read result for that port, held until next read on that port
- o_mem_en  out  1  RAM access enable
- o_mem_we  out  1  RAM write enable
- o_mem_addr  out  ADDR_W  RAM address
- o_mem_wdata  out  DATA_W  RAM write data
- i_mem_rdata  in  DATA_W  RAM read data, valid the cycle after an enabled read

## Operation
- FSM states:
  - IDLE: no access in flight; samples requests every cycle.
  - ISSUE: drives the RAM with the latched command.
  - CAPTURE: reads only; takes the returned RAM data.
- IDLE -> ISSUE: at least one request present.
  - Winner's we/addr/wdata and port id are latched at that edge.
  - Stays IDLE if there are no requests.
- ISSUE: o_mem_en=1; o_mem_we/addr/wdata come from the latch; o_gntN=1 for the latched port.
  - Next state is CAPTURE for a read, IDLE for a write.
- CAPTURE: o_rdataN <= i_mem_rdata for the latched port; o_rvalidN pulses the following cycle. Next state is IDLE.
- Arbitration, applied only when both requests are high in IDLE:
  - FIXED_PRIO=1: port 0 wins.
  - FIXED_PRIO=0: the port not granted last wins.
  - Single requester: that requester wins regardless of history.
- last_grant is updated on each IDLE->ISSUE transition.
- Requester rule: req, we, addr and wdata are held stable until gnt.
  - Dropping req while in IDLE is legal and produces no access.
  - After latching, the access always completes even if req drops.
- RAM outputs are registered. Outside ISSUE: o_mem_en=0 and o_mem_we=0; addr and wdata hold their last values.
- Reset (asserted at any time, including mid-access):
  - state IDLE; last_grant = port 1, so port 0 wins the first contention.
  - All gnt, rvalid, mem_en and mem_we = 0.
  - o_rdata0/1 = 0; o_mem_addr/wdata = 0.
  - An in-flight access is abandoned and no rvalid is issued.

## Timing
- Read: req high in cycle 0 -> ISSUE/gnt cycle 1 -> CAPTURE cycle 2 -> rvalid and o_rdata visible cycle 3. Load-to-use latency is 3 cycles.
- Write: req cycle 0 -> ISSUE/gnt with mem_we cycle 1 -> IDLE cycle 2. The RAM is written at the end of cycle 1.
- Back-to-back:
  - A new request may be sampled in the IDLE cycle that coincides with rvalid, so the next gnt arrives in cycle 4 after a read, or cycle 3 after a write.
  - Peak throughput is 1 write per 2 cycles or 1 read per 3 cycles.
- The losing requester waits for the in-flight access to finish. With round-robin, its worst-case wait is one foreign access.
- No combinational path from any i_req/i_addr to any output.

## Structure
- Package edulent_mem_pkg contains:
  - arb_state_t enum {IDLE, ISSUE, CAPTURE}
  - port id constants PORT_CPU=1'b0 and PORT_LDR=1'b1
  - default ADDR_W/DATA_W localparams shared with the RAM wrapper
- One sub-module, mem_arb_pick: combinational two-way winner select from (req0, req1, last_grant, FIXED_PRIO). It is instantiated once and unit-testable on its own.
- Everything else (latch, FSM, response registers) lives in mem_arbiter.

## Test plan
- Reset then port 0 read of addr 0x10, RAM preloaded 0xA5 -> gnt0 in cycle 1, mem_en=1/mem_we=0 with addr 0x10, rvalid0 in cycle 3 with o_rdata0=0xA5; no port 1 activity.
- Port 1 write 0x3C to 0x20, then port 0 read 0x20 -> gnt1 cycle 1 with mem_we=1; gnt0 cycle 3; o_rdata0=0x3C with rvalid0 cycle 5.
- Both ports requesting reads continuously, FIXED_PRIO=0 -> grants alternate 0,1,0,1; each rvalid lands on the matching port only; o_rdata of the other port is unchanged.
- Same stimulus with FIXED_PRIO=1 -> only port 0 is granted while req0 stays high; port 1 is granted in the first IDLE cycle after req0 drops.
- i_rst pulsed in CAPTURE of a port 1 read -> no rvalid1; all outputs 0 the cycle after reset assertion; the first post-reset contention is won by port 0.
- req0 dropped in IDLE before any grant -> no mem_en; req0 dropped in ISSUE -> the read still completes with rvalid0.
